serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial ripple adder: the addition counterpart to the team's subtractor cells.
//  - Loads two WIDTH-bit operands plus a carry-in on start.
//  - Adds one bit per clock, LSB first, through a registered carry.
//  - Presents the sum and carry-out with a one-cycle done pulse.
//  - Used where area matters more than latency: small ALUs, checksum accumulation.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2)
// PORTS
//  clk     input   1      rising-edge clock
//  rst_n   input   1      asynchronous active-low reset
//  start   input   1      request; sampled only in IDLE
//  a       input   WIDTH  operand A, captured on accepted start
//  b       input   WIDTH  operand B, captured on accepted start
//  cin     input   1      carry-in, captured on accepted start
//  busy    output  1      high while bits are being processed
//  done    output  1      one-cycle pulse: sum/cout valid
//  sum     output  WIDTH  result, held until next accepted start completes
//  cout    output  1      carry-out of MSB, held like sum
//  ovf     output  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE.
//    - busy=0, done=0, sum=0, cout=0, ovf=0.
//    - Shift registers, carry and counter cleared.
//  - FSM states IDLE, SHIFT, DONE:
//    - IDLE: start=1 at edge E0 -> load a_sh=a, b_sh=b, carry=cin, cnt=0; go to SHIFT; busy=1.
//    - SHIFT: each edge computes {c,s}=a_sh[0]+b_sh[0]+carry.
//      - Shifts a_sh and b_sh right.
//      - Shifts s into the MSB of sum_sh.
//      - carry=c; cnt++.
//    - SHIFT exit: on the edge processing bit WIDTH-1 (edge E0+WIDTH), go to DONE.
//      - sum=final sum_sh, cout=c; busy=0, done=1.
//    - DONE: next edge -> IDLE, done=0.
//  - Latency: done is visible exactly WIDTH clocks after the accepting edge.
//    - Throughput: one operation per WIDTH+2 clocks.
//  - start ignored in SHIFT and DONE (no queuing). Operand inputs are don't-care after capture.
//  - sum/cout change only on the DONE-entry edge; they never show partial results.
//  - Reset mid-operation: immediate return to reset values; the partial result is discarded.
//  - Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
//  - cnt width = $clog2(WIDTH)+1; no wrap within an operation.
// CONFIGURATION
//  - SERIAL_ADDER_OVF_EN defined:
//    - ovf port present.
//    - ovf = carry into MSB XOR carry out of MSB, registered with sum on the DONE-entry edge.
//    - ovf reset 0.
//  - SERIAL_ADDER_OVF_EN undefined:
//    - ovf port and the MSB carry-in tap are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package serial_adder_pkg:
//    - state typedef (IDLE/SHIFT/DONE, 2-bit).
//    - function cnt_w(WIDTH) returning $clog2(WIDTH)+1.
//  - Sub-module full_adder (a,b,ci -> s,co):
//    - combinational one-bit cell, instantiated once in the datapath.
//  - Everything else (FSM, shift registers, carry flop) lives in serial_adder.
// TESTING (WIDTH=8)
//  1. a=8'h0F, b=8'h01, cin=0, start -> after 8 clks done=1, sum=8'h10, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//     a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. With SERIAL_ADDER_OVF_EN:
//     - a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1.
//     - a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
//     - a=8'h05, b=8'h03 -> ovf=0.
//  4. start and new operands pulsed during SHIFT and during DONE -> ignored.
//     - First result unchanged; busy/done timing unchanged.
//  5. rst_n low at 4th SHIFT clk:
//     - busy=0, sum=0, cout=0 at once.
//     - Next start with a=8'h21, b=8'h12 -> sum=8'h33.
//  6. Random a/b/cin, 500 ops, back-to-back starts in IDLE:
//     - {cout,sum} == a+b+cin.
//     - done exactly once per op, WIDTH clks after the accepting edge.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Latency and backpressure are owned by serial_adder; this package holds only types.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; ovf exists only with SERIAL_ADDER_OVF_EN.
// No flow control of its own: start is a level sampled only while the adder is idle.
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder cell, zero latency.
// No backpressure: pure combinational logic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first; done pulses WIDTH clocks after start is accepted (SERIAL_ADDER_OVF_EN adds ovf).
// No queuing: start is sampled only in IDLE and ignored while busy or done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;
  logic last_bit;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        // Visible result updates only here, so partial sums never leak out.
        if (last_bit) begin
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
